// File: rtl/mux_n_pipe_if.sv
`default_nettype none
// ==== mux_n_pipe_if : channel-side and output-side handshake bundle for mux_n_pipe ==== rev 1.0
// master drives the inputs and consumes the output; slave is the mux itself.
interface mux_n_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_chan;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid, sel_err
  );
endinterface
`default_nettype wire

// File: rtl/mux_n_pipe.sv
`default_nettype none
// ==== mux_n_pipe : N-input valid/ready mux with registered output; define MUX_RR_EN for round-robin ==== rev 1.0
// Explicit-select by default; out_ready -> in_ready is the only combinational path.
module mux_n_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mux_n_pipe_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_IN);

  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $error("mux_n_pipe: NUM_IN must be in 2..16");
  end

  logic [SEL_W-1:0] g;
  logic             g_ok;
  logic             g_valid;
  logic [WIDTH-1:0] g_data;
  logic             space;
  logic             accept;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;

  // Gating with reset keeps any handshake from completing while reset is held.
  assign space = !reset && (!out_valid_q || bus.out_ready);

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;

  // Descending scan: the last hit written is the first valid channel at/after ptr_q.
  always_comb begin
    int idx;
    idx  = 0;
    g    = '0;
    g_ok = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_IN;
      if (bus.in_valid[idx]) begin
        g    = SEL_W'(idx);
        g_ok = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (int'(g) == NUM_IN - 1) ? '0 : g + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign sel_err_d = 1'b0;
`else
  localparam logic [SEL_W:0] C_LIMIT = (SEL_W + 1)'(NUM_IN);

  assign g         = bus.sel;
  assign g_ok      = ({1'b0, bus.sel} < C_LIMIT);
  assign sel_err_d = space && !g_ok;
`endif

  // Bounded channel pick so an out-of-range g never indexes past the bus.
  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(g) == i) begin
        g_data  = bus.in_data[i*WIDTH +: WIDTH];
        g_valid = bus.in_valid[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ready
    assign bus.in_ready[i] = space && g_ok && (int'(g) == i);
  end

  assign accept = space && g_ok && g_valid;

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = g_data;
      out_chan_d  = g;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_n_pipe.sv
`default_nettype none
// ==== tb_mux_n_pipe : directed vectors with a queue scoreboard for mux_n_pipe ==== rev 1.0
// Covers the explicit-select build by default and the round-robin build under MUX_RR_EN.
module tb_mux_n_pipe;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [35:0] q4[$];
  logic [35:0] q3[$];
  logic [35:0] e4, e3;

  always #5 clk = ~clk;

  mux_n_pipe_if #(.WIDTH(32), .NUM_IN(4)) b4();
  mux_n_pipe_if #(.WIDTH(32), .NUM_IN(3)) b3();

  mux_n_pipe #(.WIDTH(32), .NUM_IN(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
  mux_n_pipe #(.WIDTH(32), .NUM_IN(3)) u3 (.clk(clk), .reset(reset), .bus(b3));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input int s, input logic [3:0] v, input int ch, input logic [31:0] d);
    b4.sel                = 2'(s);
    b4.in_valid           = v;
    b4.in_data[ch*32 +: 32] = d;
  endtask

  // Scoreboard monitors: every consumed output word must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb4: unexpected word chan=%0d data=0x%0h, expected none", b4.out_chan, b4.out_data);
      end else begin
        e4 = q4.pop_front();
        check("sb4_word", {4'(b4.out_chan), b4.out_data}, e4);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b3.out_valid && b3.out_ready) begin
      if (q3.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb3: unexpected word chan=%0d data=0x%0h, expected none", b3.out_chan, b3.out_data);
      end else begin
        e3 = q3.pop_front();
        check("sb3_word", {4'(b3.out_chan), b3.out_data}, e3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    b4.in_data = '0; b4.in_valid = '0; b4.sel = '0; b4.out_ready = 1'b0;
    b3.in_data = '0; b3.in_valid = '0; b3.sel = '0; b3.out_ready = 1'b0;
    #1;
    check("rst_out_valid", b4.out_valid, 0);
    check("rst_out_data", b4.out_data, 0);
    check("rst_out_chan", b4.out_chan, 0);
    check("rst_sel_err", b3.sel_err, 0);
    step();
    reset = 1'b0;

`ifndef MUX_RR_EN
    // Single word from channel 2
    b4.out_ready = 1'b1;
    drive4(2, 4'b0100, 2, 32'hDEADBEEF);
    #1;
    check("t1_in_ready", b4.in_ready, 4'b0100);
    q4.push_back({4'd2, 32'hDEADBEEF});
    step();
    b4.in_valid = '0;
    check("t1_out_valid", b4.out_valid, 1);
    check("t1_out_chan", b4.out_chan, 2);
    step();
    check("t1_drained", b4.out_valid, 0);

    // Stall: 0x11 held while channel 1 waits with 0x22
    b4.out_ready = 1'b0;
    drive4(0, 4'b0001, 0, 32'h11);
    #1;
    check("t2_load_ready", b4.in_ready, 4'b0001);
    q4.push_back({4'd0, 32'h11});
    step();
    drive4(1, 4'b0010, 1, 32'h22);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_stall_ready", b4.in_ready, 0);
      check("t2_hold_data", b4.out_data, 32'h11);
      step();
    end
    b4.out_ready = 1'b1;
    #1;
    check("t2_release_ready", b4.in_ready, 4'b0010);
    q4.push_back({4'd1, 32'h22});
    step();
    b4.in_valid = '0;
    check("t2_no_bubble_valid", b4.out_valid, 1);
    check("t2_no_bubble_data", b4.out_data, 32'h22);
    step();

    // Streaming with every channel valid; only the selected one may move
    for (int i = 0; i < 4; i++) begin
      b4.sel = 2'(i);
      b4.in_valid = 4'b1111;
      b4.in_data[i*32 +: 32] = 32'hA0 + 32'(i);
      q4.push_back({4'(i), 32'hA0 + 32'(i)});
      step();
      check("t3_stream_valid", b4.out_valid, 1);
    end
    b4.in_valid = '0;
    step();

    // Out-of-range select on the 3-channel instance
    b3.out_ready = 1'b1;
    b3.sel = 2'd3;
    b3.in_valid = 3'b111;
    b3.in_data = {32'h3, 32'h2, 32'h1};
    #1;
    check("t4_oor_ready", b3.in_ready, 0);
    step();
    check("t4_sel_err", b3.sel_err, 1);
    check("t4_out_valid", b3.out_valid, 0);
    step();
    check("t4_sel_err_repeat", b3.sel_err, 1);
    b3.sel = 2'd2;
    q3.push_back({4'd2, 32'h3});
    step();
    check("t4_sel_err_clear", b3.sel_err, 0);
    check("t4_recover_valid", b3.out_valid, 1);
    b3.out_ready = 1'b0;
    b3.sel = 2'd3;
    step();
    check("t4_no_err_in_stall", b3.sel_err, 0);
    check("t4_stall_data", b3.out_data, 32'h3);
    b3.out_ready = 1'b1;
    step();
    check("t4_err_after_stall", b3.sel_err, 1);
    check("t4_drained", b3.out_valid, 0);
    b3.sel = 2'd0;
    b3.in_valid = '0;
    step();
    check("t4_final_err", b3.sel_err, 0);
`else
    // Round-robin: all channels valid -> 0,1,2,3,0
    b4.out_ready = 1'b1;
    b4.in_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    b4.in_valid = 4'b1111;
    #1;
    check("rr_first_ready", b4.in_ready, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      q4.push_back({4'(k % 4), 32'hB0 + 32'(k % 4)});
      step();
      check("rr_all_valid", b4.out_valid, 1);
    end
    b4.in_valid = '0;
    step();
    #2 reset = 1'b1;
    #1 reset = 1'b0;

    // Sparse requests 1010 from pointer 0 -> 1,3,1
    b4.in_valid = 4'b1010;
    #1;
    check("rr_sparse_ready", b4.in_ready, 4'b0010);
    q4.push_back({4'd1, 32'hB1});
    q4.push_back({4'd3, 32'hB3});
    q4.push_back({4'd1, 32'hB1});
    step();
    step();
    step();
    b4.in_valid = '0;
    #1;
    check("rr_no_grant", b4.in_ready, 0);
    step();
    b3.sel = 2'd3;
    step();
    check("rr_sel_err_tied", b3.sel_err, 0);
`endif

    // Asynchronous reset while a word is held
    b4.out_ready = 1'b0;
    drive4(3, 4'b1000, 3, 32'h55);
    q4.push_back({4'd3, 32'h55});
    step();
    b4.in_valid = '0;
    check("t5_pre_valid", b4.out_valid, 1);
    #2;
    reset = 1'b1;
    q4.delete();
    q3.delete();
    b4.out_ready = 1'b1;
    b4.in_valid = 4'b1000;
    #1;
    check("t5_async_valid", b4.out_valid, 0);
    check("t5_async_data", b4.out_data, 0);
    check("t5_async_chan", b4.out_chan, 0);
    check("t5_reset_ready", b4.in_ready, 0);
    step();
    b4.in_valid = '0;
    reset = 1'b0;
    step();

    drive4(3, 4'b1000, 3, 32'h66);
    q4.push_back({4'd3, 32'h66});
    step();
    b4.in_valid = '0;
    check("t5_recover_data", b4.out_data, 32'h66);
    repeat (3) step();

    check("q4_empty", q4.size(), 0);
    check("q3_empty", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
